// File: rtl/forprop_mac_sequencer.sv
// Sequencer feeding one forprop_neuron: fetches N_INPUTS weight/data pairs,
// runs the MAC, then presents the (optionally ReLU'd) activation on valid/ready.
module forprop_mac_sequencer #(
    parameter int N_INPUTS = 4,
    parameter int ADDR_W   = 8,
    parameter bit RELU_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] w_base,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] x_addr,
    input  logic [7:0]        w_rdata,
    input  logic [7:0]        x_rdata,
    output logic              n_clear,
    output logic              n_en,
    output logic [7:0]        n_weight,
    output logic [7:0]        n_data,
    input  logic [7:0]        n_accum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MAC,
        WAIT,
        OUT
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  cnt;
    logic              last_mac;
    logic              advance;
    logic [ADDR_W-1:0] next_idx;

    assign n_weight = w_rdata;
    assign n_data   = x_rdata;

    // cnt is the element index whose address is on the bus; the last element's
    // address is held through the final MAC cycle instead of running past it.
    assign last_mac = (cnt == CNT_W'(N_INPUTS));
    assign advance  = (int'(cnt) + 1 < N_INPUTS);
    assign next_idx = ADDR_W'(cnt) + ADDR_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        n_clear = 1'b0;
        n_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                n_clear = 1'b1;
                state_n = MAC;
            end
            MAC: begin
                n_en = 1'b1;
                if (last_mac) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                state_n = OUT;
            end
            OUT: begin
                if (out_valid && out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base      <= '0;
            cnt       <= '0;
            w_addr    <= '0;
            x_addr    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base   <= w_base;
                        w_addr <= w_base;
                        x_addr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end
                end
                CLEAR, MAC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (advance) begin
                        x_addr <= next_idx;
                        w_addr <= base + next_idx;
                    end
                end
                WAIT: begin
                    // ReLU only inspects the sign bit; the neuron's wrapped value passes through.
                    out_data  <= (RELU_EN && n_accum[7]) ? 8'h00 : n_accum;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/forprop_mac_sequencer.md
Name: forprop_mac_sequencer

Overview:
Control stage directly upstream and downstream of a forprop_neuron instance. On start it fetches N_INPUTS weight/data pairs from two synchronous-read memories, drives the neuron's clear/en/weight/data ports and captures the finished accumulator. It then applies an optional ReLU and presents the (3,5) fixed-point activation on a valid/ready output port. One sequencer serves one neuron for one dot product per start.

Parameters:
N_INPUTS, 4, number of weight/data pairs per dot product (>=1)
ADDR_W, 8, address width of weight and data memories
RELU_EN, 1, 1 = ReLU on output; 0 = pass accumulator unchanged

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
start  in  1  request one dot product; sampled only in IDLE
w_base  in  ADDR_W  weight memory base address, latched on accepted start
busy  out  1  high from accepted start until output handshake completes
done  out  1  one-cycle pulse on the cycle after output handshake
w_addr  out  ADDR_W  weight memory address (read data valid next cycle)
x_addr  out  ADDR_W  data memory address (read data valid next cycle)
w_rdata  in  8  weight memory read data, signed (3,5)
x_rdata  in  8  data memory read data, signed (3,5)
n_clear  out  1  to neuron clear
n_en  out  1  to neuron en
n_weight  out  8  to neuron weight (combinational from w_rdata)
n_data  out  8  to neuron data (combinational from x_rdata)
n_accum  in  8  from neuron accum, signed (3,5)
out_valid  out  1  activation valid
out_ready  in  1  consumer ready
out_data  out  8  activation, (3,5)

Behaviour:
- Reset asserted (any time, including mid-sequence): state IDLE immediately. busy, done, n_clear, n_en, out_valid = 0. out_data, w_addr, x_addr, counter, latched base = 0. The neuron clears on its own reset.
- States: IDLE, CLEAR, MAC, WAIT, OUT.
- IDLE: start=1 at edge e0 latches w_base, sets busy, goes to CLEAR. start=0 stays IDLE. start in any other state is ignored (not queued).
- CLEAR (1 cycle): n_clear=1, n_en=0, x_addr=0, w_addr=base+0. Goes to MAC with i=1.
- MAC (exactly N_INPUTS cycles): n_en=1, n_clear=0. n_weight/n_data carry element i-1 from the previous cycle's address. Addresses advance to element i each cycle; the final MAC cycle's address is don't-care (hold last). After the N_INPUTS-th MAC cycle, go to WAIT.
- WAIT (1 cycle): n_en=0. n_accum now reflects all products. On this edge: out_data <= (RELU_EN && n_accum[7]) ? 0 : n_accum; out_valid <= 1; go to OUT.
- OUT: out_valid and out_data held stable while out_ready=0. On the edge with out_valid && out_ready: out_valid <= 0, busy <= 0, done <= 1 for one cycle, go to IDLE. start in the cycle done is high is accepted normally (back-to-back).
- Latency: out_valid first high after edge e0+N_INPUTS+2 (N=4: 6 edges after the start edge).
- Address arithmetic wraps modulo 2^ADDR_W (base+i overflow wraps, no error).
- No arithmetic is done on data here: the neuron's wrap behaviour is passed through unchanged, and ReLU tests the sign bit only.
- n_clear and n_en are never high in the same cycle.

Test Plan:
- N=4, RELU_EN=1, w_base=0x10, weights all 0x20 (1.0), data 0x20,0x10,0x08,0x08 -> n_en high 4 cycles, out_data=0x40 (2.0), out_valid after 6 edges, done pulse after out_ready handshake.
- Same data, weights all 0xE0 (-1.0) -> accum 0xC0; RELU_EN=1 gives out_data=0x00; RELU_EN=0 gives out_data=0xC0.
- Hold out_ready=0 for 5 cycles in OUT -> out_valid=1 and out_data stable throughout, busy=1, no done; done is one cycle after ready rises.
- Pulse start during MAC and OUT -> ignored, exactly one result. start asserted in the done cycle -> second sequence starts immediately, and CLEAR precedes its first en.
- Assert reset during the 2nd MAC cycle -> all outputs 0 immediately (asynchronous). After release and a new start, the result matches a clean run.
- w_base=0xFE, N=4 -> w_addr sequence 0xFE,0xFF,0x00,0x01 (wrap), result correct for those contents.
